// File: rtl/shift_mix_columns_pkg.sv
// Shared definitions for the ShiftRows/MixColumns round stage.
// Holds the state geometry, the GF(2^8) xtime helper with its 0x1B
// reduction constant, and the state byte-index helper that SubBytes and
// AddRoundKey also use to agree on byte placement.
package shift_mix_columns_pkg;

  localparam int DATA_W  = 128;
  localparam int ROUND_W = 4;

  // Low byte of x^8 + x^4 + x^3 + x + 1 (0x11B) once x^8 has been shifted out.
  localparam logic [7:0] GF_REDUCE = 8'h1B;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
  endfunction

  // LSB position of state byte s[r][c]. Byte 0 (r=0,c=0) sits in the MSB,
  // matching the FIPS 197 input order: s[r][c] = data[127-8*(4*c+r) -: 8].
  function automatic int unsigned byte_lsb(input int unsigned r, input int unsigned c);
    return 120 - 32 * c - 8 * r;
  endfunction

endpackage

// File: rtl/shift_mix_columns_if.sv
// Bundle of the round-stage data path signals.
// Handshake: valid-only, no ready. A producer asserts valid_* for exactly one
// cycle per state and the payload (data, last-round flag, round tag) is
// qualified by that valid; the consumer must accept every valid cycle.
//   slave  : the round stage (consumes *_in, produces *_out)
//   master : the upstream/downstream environment
interface shift_mix_columns_if #(
  parameter int DATA_W  = shift_mix_columns_pkg::DATA_W,
  parameter int ROUND_W = shift_mix_columns_pkg::ROUND_W
);
  logic               valid_in;
  logic [DATA_W-1:0]  data_in;
  logic               last_round_in;
  logic [ROUND_W-1:0] round_in;

  logic               valid_out;
  logic [DATA_W-1:0]  data_out;
  logic               last_round_out;
  logic [ROUND_W-1:0] round_out;

  modport slave (
    input  valid_in, data_in, last_round_in, round_in,
    output valid_out, data_out, last_round_out, round_out
  );

  modport master (
    output valid_in, data_in, last_round_in, round_in,
    input  valid_out, data_out, last_round_out, round_out
  );
endinterface

// File: rtl/shift_mix_columns_mix_column.sv
// mix_column: combinational MixColumns on one 32-bit state column.
// Ports:
//   col_i  in  32  column, row 0 in bits [31:24]
//   col_o  out 32  mixed column, same byte order
// Matrix rows: [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02].
module mix_column
  import shift_mix_columns_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  logic [7:0] b0, b1, b2, b3;
  logic [7:0] x0, x1, x2, x3;

  assign b0 = col_i[31:24];
  assign b1 = col_i[23:16];
  assign b2 = col_i[15:8];
  assign b3 = col_i[7:0];

  assign x0 = xtime(b0);
  assign x1 = xtime(b1);
  assign x2 = xtime(b2);
  assign x3 = xtime(b3);

  // 03*b is xtime(b) ^ b.
  assign col_o[31:24] = x0 ^ (x1 ^ b1) ^ b2 ^ b3;
  assign col_o[23:16] = b0 ^ x1 ^ (x2 ^ b2) ^ b3;
  assign col_o[15:8]  = b0 ^ b1 ^ x2 ^ (x3 ^ b3);
  assign col_o[7:0]   = (x0 ^ b0) ^ b1 ^ b2 ^ x3;
endmodule

// File: rtl/shift_mix_columns.sv
// shift_mix_columns: AES-128 round stage between SubBytes and AddRoundKey.
// Stage 1 registers ShiftRows(data_in); stage 2 registers MixColumns of that
// (or the shifted state untouched on the final round). Latency 2, one state
// per cycle, no backpressure.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset, overrides valid_in
//   io     slave side of shift_mix_columns_if (valid/data/last_round/round in and out)
module shift_mix_columns
  import shift_mix_columns_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  shift_mix_columns_if.slave  io
);
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  mixed;

  logic               v1_q, v1_d;
  logic [DATA_W-1:0]  s1_data_q, s1_data_d;
  logic               s1_last_q, s1_last_d;
  logic [ROUND_W-1:0] s1_round_q, s1_round_d;

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [ROUND_W-1:0] out_round_q, out_round_d;

  // ShiftRows is pure wiring: row r rotates left by r columns.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign shifted[byte_lsb(r, c) +: 8] = io.data_in[byte_lsb(r, (c + r) % 4) +: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    mix_column u_mix_column (
      .col_i (s1_data_q[127 - 32 * c -: 32]),
      .col_o (mixed[127 - 32 * c -: 32])
    );
  end

  // Payload registers only load on their stage valid so they hold across gaps.
  always_comb begin
    v1_d        = io.valid_in;
    s1_data_d   = s1_data_q;
    s1_last_d   = s1_last_q;
    s1_round_d  = s1_round_q;
    if (io.valid_in) begin
      s1_data_d  = shifted;
      s1_last_d  = io.last_round_in;
      s1_round_d = io.round_in;
    end

    out_valid_d = v1_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_round_d = out_round_q;
    if (v1_q) begin
      out_data_d  = s1_last_q ? s1_data_q : mixed;
      out_last_d  = s1_last_q;
      out_round_d = s1_round_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_round_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_round_q <= '0;
    end else begin
      v1_q        <= v1_d;
      s1_data_q   <= s1_data_d;
      s1_last_q   <= s1_last_d;
      s1_round_q  <= s1_round_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_round_q <= out_round_d;
    end
  end

  assign io.valid_out      = out_valid_q;
  assign io.data_out       = out_data_q;
  assign io.last_round_out = out_last_q;
  assign io.round_out      = out_round_q;
endmodule

// File: tb/tb_shift_mix_columns.sv
module tb_shift_mix_columns;
  localparam int EXP_W = 128 + 1 + 4;

  logic clk = 1'b0;
  logic reset;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [EXP_W-1:0] exp_q[$];

  shift_mix_columns_if bus_if ();

  shift_mix_columns dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus_if)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic last);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] m [4][4];
    logic [127:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = d[127 - 8 * (4 * c + r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = s[r][(c + r) % 4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r + 1) % 4][c])
                ^ t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127 - 8 * (4 * c + r) -: 8] = last ? t[r][c] : m[r][c];
    return res;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [127:0] d, input logic l, input logic [3:0] r);
    bus_if.valid_in      = v;
    bus_if.data_in       = d;
    bus_if.last_round_in = l;
    bus_if.round_in      = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 1'b1, 4'hf);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus_if.valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus_if.valid_out);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.data_out !== 128'h0) $display("FAIL reset_data got %h exp 0", bus_if.data_out);
    else pass_cnt++;
    total_cnt++;
    if ({bus_if.last_round_out, bus_if.round_out} !== 5'h0)
      $display("FAIL reset_side got %b/%h exp 0/0", bus_if.last_round_out, bus_if.round_out);
    else pass_cnt++;
    drive(1'b0, 128'h0, 1'b0, 4'h0);
    reset = 1'b0;
  endtask

  task automatic test_fips_round(input logic last, input logic [127:0] exp_d, input string name);
    @(negedge clk);
    drive(1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, last, 4'h1);
    @(negedge clk);
    drive(1'b0, 128'h0, 1'b0, 4'h0);
    total_cnt++;
    if (bus_if.valid_out !== 1'b0) $display("FAIL %s_early_valid got %b exp 0", name, bus_if.valid_out);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus_if.valid_out !== 1'b1) $display("FAIL %s_valid got %b exp 1", name, bus_if.valid_out);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.data_out !== exp_d) $display("FAIL %s_data got %h exp %h", name, bus_if.data_out, exp_d);
    else pass_cnt++;
    total_cnt++;
    if ({bus_if.last_round_out, bus_if.round_out} !== {last, 4'h1})
      $display("FAIL %s_side got %b/%h exp %b/1", name, bus_if.last_round_out, bus_if.round_out, last);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus_if.valid_out !== 1'b0) $display("FAIL %s_single_pulse got %b exp 0", name, bus_if.valid_out);
    else pass_cnt++;
  endtask

  task automatic test_single_column();
    @(negedge clk);
    drive(1'b1, 128'hdb000000_00130000_00005300_00000045, 1'b0, 4'h3);
    @(negedge clk);
    drive(1'b0, 128'h0, 1'b0, 4'h0);
    @(negedge clk);
    total_cnt++;
    if (bus_if.valid_out !== 1'b1 || bus_if.data_out !== {32'h8e4da1bc, 96'h0})
      $display("FAIL single_column got %b/%h exp 1/%h", bus_if.valid_out, bus_if.data_out,
               {32'h8e4da1bc, 96'h0});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] d;
    logic [7:0] k;
    logic exp_v;
    logic [EXP_W-1:0] e;
    int seen;
    seen = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      exp_v = (cyc >= 2);
      total_cnt++;
      if (bus_if.valid_out !== exp_v) $display("FAIL b2b_valid cyc %0d got %b exp %b", cyc, bus_if.valid_out, exp_v);
      else pass_cnt++;
      if (bus_if.valid_out === 1'b1) begin
        seen++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra got %h exp none", bus_if.data_out);
        else begin
          e = exp_q.pop_front();
          if ({bus_if.data_out, bus_if.last_round_out, bus_if.round_out} !== e)
            $display("FAIL b2b_data cyc %0d got %h/%b/%h exp %h", cyc, bus_if.data_out,
                     bus_if.last_round_out, bus_if.round_out, e);
          else pass_cnt++;
        end
      end
      if (cyc < 10) begin
        k = 8'((cyc + 1) * 37);
        d = 128'hd42711aee0bf98f1b8b45de51e415230 ^ {16{k}};
        drive(1'b1, d, (cyc == 9), 4'(cyc + 1));
        exp_q.push_back({ref_round(d, (cyc == 9)), (cyc == 9), 4'(cyc + 1)});
      end else begin
        drive(1'b0, 128'h0, 1'b0, 4'h0);
      end
    end
    total_cnt++;
    if (seen != 10) $display("FAIL b2b_count got %0d exp 10", seen);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [4:0] pat;
    logic exp_v;
    logic [127:0] d;
    logic [127:0] last_out;
    logic have_out;
    logic [EXP_W-1:0] e;
    pat = 5'b01101; // bit i = valid in cycle i: 1,0,1,1,0
    have_out = 1'b0;
    last_out = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      exp_v = (cyc >= 2 && cyc < 7) ? pat[cyc - 2] : 1'b0;
      total_cnt++;
      if (bus_if.valid_out !== exp_v) $display("FAIL gap_valid cyc %0d got %b exp %b", cyc, bus_if.valid_out, exp_v);
      else pass_cnt++;
      if (bus_if.valid_out === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL gap_extra got %h exp none", bus_if.data_out);
        else begin
          e = exp_q.pop_front();
          if ({bus_if.data_out, bus_if.last_round_out, bus_if.round_out} !== e)
            $display("FAIL gap_data cyc %0d got %h exp %h", cyc, bus_if.data_out, e);
          else pass_cnt++;
        end
        last_out = bus_if.data_out;
        have_out = 1'b1;
      end else if (have_out) begin
        total_cnt++;
        if (bus_if.data_out !== last_out) $display("FAIL gap_hold cyc %0d got %h exp %h", cyc, bus_if.data_out, last_out);
        else pass_cnt++;
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      if (cyc < 5 && pat[cyc]) begin
        drive(1'b1, d, (cyc == 3), 4'(cyc + 4));
        exp_q.push_back({ref_round(d, (cyc == 3)), (cyc == 3), 4'(cyc + 4)});
      end else begin
        // Junk payload with the last-round flag set must be ignored.
        drive(1'b0, d, 1'b1, 4'hf);
      end
    end
  endtask

  task automatic test_reset_flush();
    logic [127:0] fresh;
    @(negedge clk);
    drive(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, 4'h2);
    @(negedge clk);
    drive(1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h3);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 128'hffeeddccbbaa99887766554433221100, 1'b1, 4'h7);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if (bus_if.valid_out !== 1'b0 || bus_if.data_out !== 128'h0 ||
          bus_if.last_round_out !== 1'b0 || bus_if.round_out !== 4'h0)
        $display("FAIL flush_in_reset %0d got %b/%h/%b/%h exp all 0", i, bus_if.valid_out,
                 bus_if.data_out, bus_if.last_round_out, bus_if.round_out);
      else pass_cnt++;
    end
    reset = 1'b0;
    drive(1'b0, 128'h0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if (bus_if.valid_out !== 1'b0) $display("FAIL flush_after_reset %0d got %b exp 0", i, bus_if.valid_out);
      else pass_cnt++;
    end
    fresh = 128'hd42711aee0bf98f1b8b45de51e415230;
    drive(1'b1, fresh, 1'b0, 4'h5);
    @(negedge clk);
    drive(1'b0, 128'h0, 1'b0, 4'h0);
    total_cnt++;
    if (bus_if.valid_out !== 1'b0) $display("FAIL fresh_early got %b exp 0", bus_if.valid_out);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus_if.valid_out !== 1'b1 || bus_if.data_out !== 128'h046681e5e0cb199a48f8d37a2806264c ||
        bus_if.round_out !== 4'h5 || bus_if.last_round_out !== 1'b0)
      $display("FAIL fresh_after_reset got %b/%h/%h exp 1/046681e5e0cb199a48f8d37a2806264c/5",
               bus_if.valid_out, bus_if.data_out, bus_if.round_out);
    else pass_cnt++;
  endtask

  initial begin
    drive(1'b0, 128'h0, 1'b0, 4'h0);
    test_reset();
    test_fips_round(1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, "round1");
    test_fips_round(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, "last_round");
    test_single_column();
    test_back_to_back();
    test_gaps();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
